// File: rtl/lmr_pkg.sv
// Shared types and constants for the line memory responder.
package lmr_pkg;

    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_W single-port synchronous RAM; only the read register is reset.
module line_ram #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // The read register holds its value between reads so data_o stays stable.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for whole-line dcache requests with fixed latency.
// Optional protocol checker enabled by defining LMR_PROTO_CHECK_EN.
module line_mem_responder
    import lmr_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              proto_err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              ramWe, ramRe;
    logic [IDX_W-1:0]  ramIdx;
    logic              unusedBits;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // The RAM is accessed only on the WAIT->ACK transition, using the latched request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        ramWe   = 1'b0;
        ramRe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    addr_d  = addr_i;
                    write_d = write_i;
                    data_d  = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    ramWe   = write_q;
                    ramRe   = !write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ramIdx     = addr_q[OFFSET_W +: IDX_W];
    assign unusedBits = ^{addr_q[ADDR_W-1:OFFSET_W+IDX_W], addr_q[OFFSET_W-1:0]};

    // Gating the write with reset keeps an interrupted request from committing.
    line_ram #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ramWe && rst_i),
        .re_i    (ramRe),
        .idx_i   (ramIdx),
        .wdata_i (data_q),
        .rdata_o (data_o)
    );

    assign ack_o = ack_q;

`ifdef LMR_PROTO_CHECK_EN
    logic protoErr_q, protoErr_d;
    logic waitViolation, acceptViolation;

    always_comb begin
        waitViolation   = (state_q == WAIT) &&
                          (!enable_i || (addr_i != addr_q) ||
                           (write_i != write_q) || (data_i != data_q));
        acceptViolation = (state_q == IDLE) && enable_i &&
                          (addr_i[OFFSET_W-1:0] != '0);
        protoErr_d      = protoErr_q | waitViolation | acceptViolation;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            protoErr_q <= 1'b0;
        end else begin
            protoErr_q <= protoErr_d;
        end
    end

    assign proto_err_o = protoErr_q;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule
